// File: rtl/psum_pkg.sv
// psum_pkg: lane-bus constants shared by the partial-sum packer and the adder tree.
`default_nettype none

package psum_pkg;
  localparam int LANE_W = 20;
  localparam int LANES  = 8;
  localparam int BUS_W  = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int IDX_W  = $clog2(LANES);
endpackage

`default_nettype wire

// File: rtl/psum_lane_packer.sv
// psum_lane_packer: packs LANES serial partial sums into one lane-bus frame.
// Optional early close on in_last is enabled by defining PSUM_PACKER_LAST_EN.
`default_nettype none

module psum_lane_packer
  import psum_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUS_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [BUS_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [BUS_W-1:0] frame;
  logic             last_close;
  logic             at_full;
  logic             closing;
  logic             slot_free;
  logic             accept;
  logic             close_fire;

`ifdef PSUM_PACKER_LAST_EN
  assign last_close = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_close     = 1'b0;
`endif

  assign at_full    = (cnt_q == IDX_W'(LANES - 1));
  assign closing    = at_full || last_close;
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = slot_free || !closing;
  assign accept     = in_valid && in_ready;
  assign close_fire = accept && closing;

  // Lanes above cnt are always zero, so the frame is just the buffer with in_data spliced in.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic              hit;
    logic [LANE_W-1:0] lane_q;

    assign hit = (cnt_q == IDX_W'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else if (close_fire) begin
        lane_q <= '0;
      end else if (accept && hit) begin
        lane_q <= in_data;
      end
    end

    assign frame[k*LANE_W +: LANE_W] = hit ? in_data : lane_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (close_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = frame;
      out_count_d = CNT_W'(cnt_q) + CNT_W'(1);
      cnt_d       = '0;
    end else if (accept) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

`default_nettype wire

// File: doc/psum_lane_packer.md
# psum_lane_packer

Serial-to-parallel packer that feeds the 8-lane partial-sum adder tree. It accepts one 20-bit partial sum per cycle from a systolic-array column drain over a valid/ready stream. It assembles eight consecutive sums into the 160-bit lane bus the adder tree consumes, and presents each packed frame on a registered valid/ready output. It is the writer side of the adder tree's lane bus: lane k occupies bits [20*(k+1)-1 : 20*k].

## Interface
- LANE_W, 20, width of one partial sum
- LANES, 8, lanes per packed frame
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last valid this cycle
- in_ready  output  1  packer accepts the beat this cycle (combinational)
- in_data  input  LANE_W  partial sum, unsigned
- in_last  input  1  final sum of a group; flushes a partial frame (see Configuration)
- out_valid  output  1  packed frame held on out_data
- out_ready  input  1  adder tree consumes the frame this cycle
- out_data  output  LANE_W*LANES  packed frame, first-received sum in lane 0
- out_count  output  $clog2(LANES+1)  number of populated lanes in out_data (1..LANES)

## Operation
- Beat accepted when in_valid && in_ready.
- Assembly buffer: LANES x LANE_W registers plus lane counter cnt (0..LANES-1).
- Each accepted beat writes in_data into lane cnt.
- Closing beat: cnt == LANES-1, or in_last with PSUM_PACKER_LAST_EN defined.
- Non-closing beat: cnt increments.
- Closing beat, same edge:
  - Assembly lanes 0..cnt-1 plus in_data in lane cnt move into the output register.
  - out_count <= cnt+1 and out_valid <= 1.
  - Assembly buffer clears to zero and cnt <= 0.
- Unwritten lanes of a partial frame are zero, so the adder tree sum is unaffected.
- slot_free = !out_valid || out_ready.
- in_ready = slot_free || (cnt != LANES-1 && !(in_last && LAST_EN)). Non-closing beats are never stalled. A closing beat waits for the output slot.
- Output handshake: out_valid && out_ready with no closing beat → out_valid <= 0. out_data and out_count hold their last value.
- Closing beat and output handshake in the same cycle: the new frame replaces the old one and out_valid stays 1. Full-rate streaming, no bubble.
- out_data and out_count are stable while out_valid && !out_ready.
- in_data is not altered; no arithmetic and no width growth.

## Timing
- Reset values: out_valid 0, out_data 0, out_count 0, cnt 0, assembly buffer 0. in_ready = 1 immediately after reset.
- Latency: the closing beat accepted at edge N gives out_valid = 1 after edge N (1 cycle).
- Throughput: 1 lane per cycle sustained; with out_ready tied high, one frame per LANES cycles.
- Backpressure: with out_valid high and out_ready low, beats up to cnt == LANES-1 are still accepted. The closing beat stalls until out_ready.
- Reset asserted mid-frame: all state clears asynchronously and the partial frame is discarded. No output appears after release.
- in_last with cnt == LANES-1 behaves as a normal full close, out_count = LANES.

## Configuration
- PSUM_PACKER_LAST_EN defined:
  - in_last closes a frame early, zero-padded, with out_count = cnt+1.
  - in_ready depends on in_last as specified above.
- PSUM_PACKER_LAST_EN undefined:
  - in_last is ignored; the port remains present.
  - Frames close only at LANES beats, and out_count is always LANES on valid output.

## Structure
- Shared package psum_pkg holds LANE_W, LANES, BUS_W = LANE_W*LANES, and CNT_W = $clog2(LANES+1). The adder tree and packer import the same constants.
- Single module, no sub-module. The assembly buffer is a generate loop of per-lane write-enabled registers inside the module.

## Test plan
- Stream 1..8 continuously with out_ready = 1 → one frame one cycle after the 8th beat: lane0 = 1 … lane7 = 8, out_count = 8, in_ready never low.
- Stream 16 beats 0x00001..0x00010 with out_ready = 1 → two back-to-back frames with no bubble: second frame lane0 = 0x00009, lane7 = 0x00010.
- Hold out_ready = 0 after the first frame while streaming: beats 9..15 accepted, beat 16 stalled (in_ready = 0). Raise out_ready → frame 1 consumed and frame 2 loaded on the same edge.
- LAST_EN: send 0xFFFFF, 0x00003, 0x00005 with in_last on the third beat → out_count = 3, lanes 3..7 = 0, lanes 0..2 = 0xFFFFF, 0x00003, 0x00005.
- Without LAST_EN, same stimulus → no output until 5 more beats arrive; out_count = 8.
- Assert rst_n low after 5 beats, release, then send 8 beats of 0x00007 → single frame of all 0x00007; the earlier beats never appear.
